// File: rtl/lc3_execute.sv
// rtl/lc3_execute.sv - LC-3 execute stage: ALU, address adder, bypass muxing, stage registers
// Optional feature macro: EXEC_BYPASS_EN (operand bypass muxes active when defined)
module lc3_execute #(
  parameter int DW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable_execute,
  input  logic [DW-1:0] IR,
  input  logic [5:0]    E_Control,
  input  logic [DW-1:0] npc_in,
  input  logic [1:0]    W_Control_in,
  input  logic          Mem_Control_in,
  input  logic [DW-1:0] VSR1,
  input  logic [DW-1:0] VSR2,
  input  logic          bypass_alu_1,
  input  logic          bypass_alu_2,
  input  logic          bypass_mem_1,
  input  logic          bypass_mem_2,
  input  logic [DW-1:0] Mem_Bypass_Val,
  output logic [DW-1:0] aluout,
  output logic [DW-1:0] pcout,
  output logic [1:0]    W_Control_out,
  output logic          Mem_Control_out,
  output logic [DW-1:0] M_Data,
  output logic [2:0]    dr,
  output logic [2:0]    sr1,
  output logic [2:0]    sr2,
  output logic [2:0]    NZP,
  output logic [DW-1:0] IR_Exec
);

  logic [1:0]    alu_control;
  logic [1:0]    pcselect1;
  logic          pcselect2;
  logic          op2select;
  logic [3:0]    opcode;

  logic [DW-1:0] aluout_q, aluout_d;
  logic [DW-1:0] pcout_q, pcout_d;
  logic [1:0]    w_control_q;
  logic          mem_control_q;
  logic [DW-1:0] m_data_q;
  logic [2:0]    dr_q;
  logic [2:0]    nzp_q, nzp_d;
  logic [DW-1:0] ir_q;

  logic [DW-1:0] op1;
  logic [DW-1:0] op2;
  logic [DW-1:0] alu_b;
  logic [DW-1:0] alu_res;
  logic [DW-1:0] offset;
  logic [DW-1:0] base;

  assign alu_control = E_Control[5:4];
  assign pcselect1   = E_Control[3:2];
  assign pcselect2   = E_Control[1];
  assign op2select   = E_Control[0];
  assign opcode      = IR[15:12];

  // Source register indices follow IR directly; stores read the data register via sr2
  always_comb begin
    sr1 = IR[8:6];
    if (opcode == 4'b0011 || opcode == 4'b0111 || opcode == 4'b1011) begin
      sr2 = IR[11:9];
    end else begin
      sr2 = IR[2:0];
    end
  end

`ifdef EXEC_BYPASS_EN
  // Operand resolution: ALU forwarding outranks memory forwarding
  always_comb begin
    if (bypass_alu_1) begin
      op1 = aluout_q;
    end else if (bypass_mem_1) begin
      op1 = Mem_Bypass_Val;
    end else begin
      op1 = VSR1;
    end
    if (bypass_alu_2) begin
      op2 = aluout_q;
    end else if (bypass_mem_2) begin
      op2 = Mem_Bypass_Val;
    end else begin
      op2 = VSR2;
    end
  end
`else
  // Forwarding disabled: operands come straight from the register file
  logic unused_bypass;
  assign unused_bypass = ^{bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2, Mem_Bypass_Val};

  always_comb begin
    op1 = VSR1;
    op2 = VSR2;
  end
`endif

  // ALU: second input is either the resolved operand 2 or the 5-bit immediate
  always_comb begin
    alu_b = op2select ? op2 : {{(DW-5){IR[4]}}, IR[4:0]};
    case (alu_control)
      2'b00:   alu_res = op1 + alu_b;
      2'b01:   alu_res = op1 & alu_b;
      2'b10:   alu_res = ~op1;
      default: alu_res = op1;
    endcase
  end

  // Address adder: PC-relative or register-relative offset
  always_comb begin
    case (pcselect1)
      2'b00:   offset = {{(DW-11){IR[10]}}, IR[10:0]};
      2'b01:   offset = {{(DW-9){IR[8]}}, IR[8:0]};
      2'b10:   offset = {{(DW-6){IR[5]}}, IR[5:0]};
      default: offset = '0;
    endcase
    base    = pcselect2 ? npc_in : op1;
    pcout_d = base + offset;
  end

  // Result select and branch mask derived from opcode
  always_comb begin
    if (opcode == 4'b0001 || opcode == 4'b0101 || opcode == 4'b1001) begin
      aluout_d = alu_res;
    end else begin
      aluout_d = pcout_d;
    end
    if (opcode == 4'b0000) begin
      nzp_d = IR[11:9];
    end else if (opcode == 4'b1100) begin
      nzp_d = 3'b111;
    end else begin
      nzp_d = 3'b000;
    end
  end

  // Stage registers: cleared asynchronously, advance only when enabled
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      aluout_q      <= '0;
      pcout_q       <= '0;
      w_control_q   <= '0;
      mem_control_q <= 1'b0;
      m_data_q      <= '0;
      dr_q          <= '0;
      nzp_q         <= '0;
      ir_q          <= '0;
    end else if (enable_execute) begin
      aluout_q      <= aluout_d;
      pcout_q       <= pcout_d;
      w_control_q   <= W_Control_in;
      mem_control_q <= Mem_Control_in;
      m_data_q      <= op2;
      dr_q          <= IR[11:9];
      nzp_q         <= nzp_d;
      ir_q          <= IR;
    end
  end

  assign aluout          = aluout_q;
  assign pcout           = pcout_q;
  assign W_Control_out   = w_control_q;
  assign Mem_Control_out = mem_control_q;
  assign M_Data          = m_data_q;
  assign dr              = dr_q;
  assign NZP             = nzp_q;
  assign IR_Exec         = ir_q;

endmodule

// File: doc/lc3_execute.md
Name: lc3_execute

Overview:
- LC-3 Execute stage. Sits directly downstream of the Decode stage.
- Consumes Decode's IR, E_Control, npc_out, Mem_Control and W_Control, and is clocked forward by enable_execute.
- Performs ALU operations (ADD/AND/NOT) and effective-address / branch-target calculation. Applies ALU and memory bypass muxing.
- Registers results for the MemAccess and Writeback stages.

Parameters:
- DW, 16, datapath width (fixed by the LC-3 ISA; do not override).

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- enable_execute  input  1  stage advance; registers load only when 1.
- IR  input  16  instruction from Decode.
- E_Control  input  6  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}.
- npc_in  input  16  PC+1 from Decode.
- W_Control_in  input  2  writeback control from Decode.
- Mem_Control_in  input  1  memory control from Decode.
- VSR1  input  16  register file read value, port 1.
- VSR2  input  16  register file read value, port 2.
- bypass_alu_1  input  1  operand 1 takes the registered aluout.
- bypass_alu_2  input  1  operand 2 takes the registered aluout.
- bypass_mem_1  input  1  operand 1 takes Mem_Bypass_Val.
- bypass_mem_2  input  1  operand 2 takes Mem_Bypass_Val.
- Mem_Bypass_Val  input  16  forwarded memory data.
- aluout  output  16  ALU result or effective address.
- pcout  output  16  address-adder result.
- W_Control_out  output  2  registered W_Control_in.
- Mem_Control_out  output  1  registered Mem_Control_in.
- M_Data  output  16  store data (resolved operand 2).
- dr  output  3  registered IR[11:9].
- sr1  output  3  combinational IR[8:6].
- sr2  output  3  combinational: IR[11:9] for ST/STR/STI (opcodes 0011/0111/1011), else IR[2:0].
- NZP  output  3  branch condition mask.
- IR_Exec  output  16  registered IR.

Behaviour:
- Reset: all registered outputs clear to 0 immediately, independent of clock. Covers aluout, pcout, W_Control_out, Mem_Control_out, M_Data, dr, NZP, IR_Exec. sr1/sr2 follow IR at all times.
- Latency: one cycle. Values present with enable_execute=1 appear on outputs after the next rising edge.
- enable_execute=0: every register holds its value; inputs are ignored.
- Operand 1 mux, priority order:
  - bypass_alu_1 → aluout;
  - else bypass_mem_1 → Mem_Bypass_Val;
  - else VSR1.
- Operand 2 mux: same priority using bypass_alu_2 / bypass_mem_2 / VSR2. Both bypass bits high: ALU bypass wins.
- op2select: 1 → operand 2; 0 → sign-extended IR[4:0].
- alu_control:
  - 00 = op1 + op2 (mod 2^16, carry dropped);
  - 01 = op1 & op2;
  - 10 = ~op1;
  - 11 = op1 pass-through.
- Address adder, offset selected by pcselect1:
  - 00 = sext IR[10:0];
  - 01 = sext IR[8:0];
  - 10 = sext IR[5:0];
  - 11 = 0.
- Address adder base: pcselect2=1 → npc_in, 0 → operand 1. Sum mod 2^16.
- pcout <= adder sum.
- aluout <= ALU result when IR[15:12] ∈ {0001, 0101, 1001}; otherwise <= adder sum.
- M_Data <= resolved operand 2 (bypass applied, before the op2select mux).
- NZP <= IR[11:9] for BR (0000); 3'b111 for JMP (1100); 3'b000 otherwise.
- W_Control_out, Mem_Control_out, dr, IR_Exec: registered copies of their inputs.
- Reset deasserting with enable_execute=1: the first qualifying edge loads normally.

Optional Feature:
- Macro: EXEC_BYPASS_EN.
- Defined: the bypass muxes operate as described above.
- Undefined: the bypass_* and Mem_Bypass_Val ports remain present but are ignored. Operand 1 = VSR1, operand 2 = VSR2 unconditionally.

Test Plan:
1. Register-mode ADD: IR=16'h1642, E_Control=6'b000001, VSR1=5, VSR2=7, enable=1 → next edge: aluout=16'h000C, dr=3, sr1=1, sr2=2, NZP=0.
2. Immediate ADD wrap: IR=16'h1261, op2select=0, VSR1=16'hFFFF → aluout=16'h0000.
3. NOT: IR=16'h967F, alu_control=10, VSR1=16'h00F0 → aluout=16'hFF0F.
4. BR: IR=16'h0E05, npc_in=16'h3001, E_Control=6'b000110 → pcout=aluout=16'h3006, NZP=3'b111.
5. Bypass (EXEC_BYPASS_EN defined): after test 1 (aluout=12), IR=16'h1261, bypass_alu_1=1, bypass_mem_1=1, VSR1=0 → aluout=13. With the macro undefined → aluout=1.
6. Hold/reset:
   - enable_execute=0 for 3 cycles with changing inputs → outputs unchanged.
   - Assert reset mid-cycle → all registered outputs 0 before the next edge.
